// File: rtl/vend_coin_sched.sv
// vend_coin_sched
// Shares one credit accumulator between N_SLOT coin acceptors. Coins are
// arbitrated round-robin, one per cycle. When credit reaches PRICE a one-cycle
// sell pulse is issued. Any remainder, or a cancelled credit, is then paid back
// as change pulses spaced PAY_GAP idle cycles apart.
//
// Optional build macro: VEND_COIN_TIMEOUT_EN
//   When defined, a COLLECT phase with no ack for TIMEOUT cycles refunds the
//   full credit, using the same sequencing as a cancel.
//   When undefined, COLLECT waits indefinitely for more coins or a cancel.
module vend_coin_sched #(
  parameter int N_SLOT  = 2,    // coin acceptor channels, 2..4
  parameter int PRICE   = 5,    // item price in coin units, 2..13
  parameter int CW      = 4,    // credit width, must hold PRICE+1
  parameter int PAY_GAP = 2,    // idle cycles between change pulses, >=1
  parameter int TIMEOUT = 200   // COLLECT inactivity limit (optional feature)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [N_SLOT-1:0]     coin_req,
  input  logic [2*N_SLOT-1:0]   coin_val,
  input  logic                  cancel,
  output logic [N_SLOT-1:0]     coin_ack,
  output logic                  coin_err,
  output logic                  sell,
  output logic                  change,
  output logic                  busy,
  output logic [CW-1:0]         credit
);

  localparam int PW = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
  localparam int GW = $clog2(PAY_GAP + 1);
  localparam logic [CW-1:0] PRICE_C  = CW'(PRICE);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [GW-1:0] GAP_C    = GW'(PAY_GAP);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(N_SLOT - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_PAYOUT  = 2'd3
  } state_t;

  // Only one- and two-unit coins carry value; codes 0 and 3 are rejected.
  function automatic logic coin_is_legal(input logic [1:0] v);
    return (v == 2'd1) || (v == 2'd2);
  endfunction

  // Registered state and outputs
  state_t              r_state;
  logic [PW-1:0]       r_ptr;
  logic [N_SLOT-1:0]   r_ack;
  logic                r_err;
  logic                r_sell;
  logic                r_change;
  logic                r_busy;
  logic [CW-1:0]       r_credit;
  logic [GW-1:0]       r_gap;

  // Combinational decisions for the current cycle
  logic                w_arb_en;
  logic [N_SLOT-1:0]   w_cand;
  logic                w_grant_vld;
  logic [PW-1:0]       w_grant_idx;
  logic [1:0]          w_val;
  logic                w_legal;
  logic [CW-1:0]       w_add;
  logic [CW-1:0]       w_sum;
  logic [PW-1:0]       w_ptr_nxt;
  logic [N_SLOT-1:0]   w_ack_nxt;
  logic                w_vend;
  logic                w_refund;
  logic                w_to_hit;
  logic                w_to_fire;

  // Coins are accepted only while idle or still short of the price. Once the
  // price is reached no further coin is taken, so credit never exceeds PRICE+1.
  assign w_arb_en = (r_state == S_IDLE) ||
                    ((r_state == S_COLLECT) && (r_credit < PRICE_C));

  // Round-robin search from the pointer. The slot acked this cycle is masked
  // because its requester has not yet had a chance to drop req.
  always_comb begin
    int  k;
    logic hit;
    k           = 0;
    hit         = 1'b0;
    w_cand      = coin_req & ~r_ack;
    w_grant_vld = 1'b0;
    w_grant_idx = {PW{1'b0}};
    for (int j = 0; j < N_SLOT; j++) begin
      k           = ((int'(r_ptr) + j) >= N_SLOT) ? (int'(r_ptr) + j - N_SLOT)
                                                  : (int'(r_ptr) + j);
      hit         = w_arb_en && w_cand[k] && !w_grant_vld;
      w_grant_idx = hit ? PW'(k) : w_grant_idx;
      w_grant_vld = w_grant_vld | hit;
    end
  end

  // Value, credit sum, next pointer and ack vector for the granted coin.
  always_comb begin
    w_val     = coin_val[{w_grant_idx, 1'b0} +: 2];
    w_legal   = w_grant_vld && coin_is_legal(w_val);
    w_add     = w_legal ? {{(CW-2){1'b0}}, w_val} : {CW{1'b0}};
    w_sum     = r_credit + w_add;
    w_ptr_nxt = (w_grant_idx == PTR_LAST) ? {PW{1'b0}} : (w_grant_idx + PTR_ONE);
    w_ack_nxt = w_grant_vld ? ({{(N_SLOT-1){1'b0}}, 1'b1} << w_grant_idx)
                            : {N_SLOT{1'b0}};
  end

  // COLLECT exits. Vend takes priority over cancel. A coin granted in the
  // same cycle as a refund is included in it, because w_sum carries the coin.
  assign w_vend    = (r_state == S_COLLECT) && (r_credit >= PRICE_C);
  assign w_to_fire = (r_state == S_COLLECT) && !w_grant_vld && w_to_hit;
  assign w_refund  = (r_state == S_COLLECT) && (cancel || w_to_fire) &&
                     (w_sum != {CW{1'b0}});

`ifdef VEND_COIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;

  // Counts COLLECT cycles since entry or the last ack; held at zero elsewhere.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_to_cnt <= {TW{1'b0}};
    end else if ((r_state == S_COLLECT) && !w_grant_vld && !w_vend && !w_refund) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end else begin
      r_to_cnt <= {TW{1'b0}};
    end
  end

  assign w_to_hit = (r_to_cnt == TW'(TIMEOUT - 1));
`else
  // The inactivity refund is compiled out, so this never fires. TIMEOUT is
  // kept so the parameter list is identical in both builds.
  assign w_to_hit = (TIMEOUT < 1);
`endif

  // Main controller. It handles arbitration bookkeeping, credit and the
  // IDLE/COLLECT/VEND/PAYOUT sequencing, and drives all registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= {PW{1'b0}};
      r_ack    <= {N_SLOT{1'b0}};
      r_err    <= 1'b0;
      r_sell   <= 1'b0;
      r_change <= 1'b0;
      r_busy   <= 1'b0;
      r_credit <= {CW{1'b0}};
      r_gap    <= {GW{1'b0}};
    end else begin
      // Defaults: pulses drop and the ack mirrors this cycle's grant.
      r_ack    <= w_ack_nxt;
      r_err    <= w_grant_vld && !w_legal;
      r_sell   <= 1'b0;
      r_change <= 1'b0;
      r_ptr    <= w_grant_vld ? w_ptr_nxt : r_ptr;

      case (r_state)
        S_IDLE: begin
          r_credit <= w_sum;
          r_busy   <= 1'b0;
          r_gap    <= {GW{1'b0}};
          if (w_legal) begin
            r_state <= S_COLLECT;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_COLLECT: begin
          if (w_vend) begin
            r_state  <= S_VEND;
            r_sell   <= 1'b1;
            r_credit <= r_credit - PRICE_C;
            r_busy   <= 1'b1;
            r_gap    <= {GW{1'b0}};
          end else if (w_refund) begin
            // The first change pulse is issued on entry to PAYOUT.
            r_state  <= S_PAYOUT;
            r_change <= 1'b1;
            r_credit <= w_sum - ONE_C;
            r_busy   <= 1'b1;
            r_gap    <= GAP_C;
          end else begin
            r_state  <= S_COLLECT;
            r_credit <= w_sum;
            r_busy   <= 1'b0;
            r_gap    <= {GW{1'b0}};
          end
        end

        S_VEND: begin
          if (r_credit != {CW{1'b0}}) begin
            r_state  <= S_PAYOUT;
            r_change <= 1'b1;
            r_credit <= r_credit - ONE_C;
            r_busy   <= 1'b1;
            r_gap    <= GAP_C;
          end else begin
            r_state  <= S_IDLE;
            r_credit <= r_credit;
            r_busy   <= 1'b0;
            r_gap    <= {GW{1'b0}};
          end
        end

        S_PAYOUT: begin
          if (r_credit == {CW{1'b0}}) begin
            r_state  <= S_IDLE;
            r_credit <= r_credit;
            r_busy   <= 1'b0;
            r_gap    <= {GW{1'b0}};
          end else if (r_gap != {GW{1'b0}}) begin
            // Spacing cycles between change pulses.
            r_state  <= S_PAYOUT;
            r_credit <= r_credit;
            r_busy   <= 1'b1;
            r_gap    <= r_gap - GAP_ONE;
          end else begin
            r_state  <= S_PAYOUT;
            r_change <= 1'b1;
            r_credit <= r_credit - ONE_C;
            r_busy   <= 1'b1;
            r_gap    <= GAP_C;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_credit <= {CW{1'b0}};
          r_busy   <= 1'b0;
          r_gap    <= {GW{1'b0}};
        end
      endcase
    end
  end

  assign coin_ack = r_ack;
  assign coin_err = r_err;
  assign sell     = r_sell;
  assign change   = r_change;
  assign busy     = r_busy;
  assign credit   = r_credit;

endmodule

// File: tb/tb_vend_coin_sched.sv
// Self-checking bench for vend_coin_sched: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a behavioural model.
module tb_vend_coin_sched;

  localparam int N_SLOT  = 2;
  localparam int PRICE   = 5;
  localparam int CW      = 4;
  localparam int PAY_GAP = 2;
`ifdef VEND_COIN_TIMEOUT_EN
  localparam int TIMEOUT = 10;
`else
  localparam int TIMEOUT = 200;
`endif
  localparam int G = PAY_GAP + 1;   // cycles from one change pulse to the next

  logic                 sys_clk = 1'b0;
  logic                 sys_rst = 1'b1;
  logic [N_SLOT-1:0]    coin_req = '0;
  logic [2*N_SLOT-1:0]  coin_val = '0;
  logic                 cancel = 1'b0;
  logic [N_SLOT-1:0]    coin_ack;
  logic                 coin_err;
  logic                 sell;
  logic                 change;
  logic                 busy;
  logic [CW-1:0]        credit;

  vend_coin_sched #(
    .N_SLOT(N_SLOT), .PRICE(PRICE), .CW(CW), .PAY_GAP(PAY_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .coin_req(coin_req), .coin_val(coin_val),
    .cancel(cancel), .coin_ack(coin_ack), .coin_err(coin_err), .sell(sell),
    .change(change), .busy(busy), .credit(credit)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int ack, input int err, input int sl,
                         input int ch, input int bz, input int cr);
    chk({tag, "_ack"},    coin_ack, ack);
    chk({tag, "_err"},    coin_err, err);
    chk({tag, "_sell"},   sell,     sl);
    chk({tag, "_change"}, change,   ch);
    chk({tag, "_busy"},   busy,     bz);
    chk({tag, "_credit"}, credit,   cr);
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int M_IDLE = 0, M_COLL = 1, M_VEND = 2, M_PAY = 3;
  bit                model_on = 1'b0;
  int                m_mode, m_ptr, m_cyc, m_n0, m_units, m_evt;
  logic [N_SLOT-1:0] e_ack;
  int                e_err, e_sell, e_change, e_busy, e_credit;

  task automatic model_reset();
    m_mode = M_IDLE; m_ptr = 0; m_cyc = 0; m_n0 = 0; m_units = 0; m_evt = 0;
    e_ack = '0; e_err = 0; e_sell = 0; e_change = 0; e_busy = 0; e_credit = 0;
  endtask

  // Refund of u units starting at edge n: pulses at n, n+G, n+2G, ...
  task automatic start_pay(input int n, input int u);
    m_mode = M_PAY; m_n0 = n; m_units = u;
    e_change = 1; e_credit = u - 1; e_busy = 1;
  endtask

  task automatic model_step();
    int n, g, k, v, idx;
    logic [N_SLOT-1:0] prev_ack;
    bit legal;
    m_cyc++;
    n = m_cyc;
    prev_ack = e_ack;
    e_ack = '0; e_err = 0; e_sell = 0; e_change = 0;
    legal = 1'b0;
    g = -1;
    case (m_mode)
      M_PAY: begin
        k = n - m_n0;
        if (k <= (m_units - 1) * G) begin
          e_change = ((k % G) == 0) ? 1 : 0;
          e_credit = m_units - (k / G + 1);
          e_busy   = 1;
        end else begin
          m_mode = M_IDLE; e_credit = 0; e_busy = 0;
        end
      end
      M_VEND: begin
        if (e_credit > 0) start_pay(n, e_credit);
        else begin m_mode = M_IDLE; e_busy = 0; end
      end
      default: begin
        if (m_mode == M_COLL && e_credit >= PRICE) begin
          e_sell = 1; e_credit = e_credit - PRICE; m_mode = M_VEND; e_busy = 1;
        end else begin
          for (int j = 0; j < N_SLOT; j++) begin
            idx = (m_ptr + j) % N_SLOT;
            if (g < 0 && coin_req[idx] && !prev_ack[idx]) g = idx;
          end
          if (g >= 0) begin
            e_ack[g] = 1'b1;
            v = int'(coin_val[2*g +: 2]);
            m_ptr = (g + 1) % N_SLOT;
            if (v == 1 || v == 2) begin legal = 1'b1; e_credit = e_credit + v; end
            else e_err = 1;
          end
          e_busy = 0;
          if (m_mode == M_COLL) begin
            if (g >= 0) m_evt = n;
            if (cancel) start_pay(n, e_credit);
`ifdef VEND_COIN_TIMEOUT_EN
            else if (g < 0 && (n - m_evt) >= TIMEOUT) start_pay(n, e_credit);
`endif
          end else if (legal) begin
            m_mode = M_COLL; m_evt = n;
          end
        end
      end
    endcase
  endtask

  // One clock: model advances on the edge, outputs are checked on the falling edge.
  task automatic tick();
    @(posedge sys_clk);
    if (model_on) model_step();
    @(negedge sys_clk);
  endtask

  task automatic apply_reset();
    coin_req = '0; coin_val = '0; cancel = 1'b0; sys_rst = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [1:0] req;
    logic [3:0] val;
    logic       cncl;
    logic [1:0] ack;
    logic       err;
    logic       sl;
    logic       ch;
    logic       bz;
    logic [3:0] cr;
  } vec_t;

  vec_t tv [19];

  // Leaves 3 units of credit in COLLECT, ready for a cancel.
  task automatic load_credit3();
    apply_reset();
    coin_req = 2'b01; coin_val = 4'b0010; tick();
    coin_req = 2'b00; tick();
    coin_req = 2'b01; coin_val = 4'b0001; tick();
    coin_req = 2'b00;
    chk("load3_credit", credit, 3);
  endtask

  initial begin
    int r;
    // Slot0 coins 2,2,1 -> sell with exact price, back to IDLE
    tv[0]  = '{2'b01, 4'b0010, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
    tv[1]  = '{2'b00, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
    tv[2]  = '{2'b01, 4'b0010, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4};
    tv[3]  = '{2'b00, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4};
    tv[4]  = '{2'b01, 4'b0001, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5};
    tv[5]  = '{2'b00, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
    tv[6]  = '{2'b00, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    // Slot0 2,2 then slot1 2 -> credit 6, sell, one change pulse
    tv[7]  = '{2'b01, 4'b0010, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
    tv[8]  = '{2'b00, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
    tv[9]  = '{2'b01, 4'b0010, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4};
    tv[10] = '{2'b00, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4};
    tv[11] = '{2'b10, 4'b1000, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6};
    tv[12] = '{2'b00, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1};
    tv[13] = '{2'b00, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0};
    tv[14] = '{2'b00, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    // Illegal values 3 and 0, then cancel while IDLE (ignored)
    tv[15] = '{2'b01, 4'b0011, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tv[16] = '{2'b00, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tv[17] = '{2'b10, 4'b0000, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tv[18] = '{2'b00, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

    // Reset values while reset is held
    @(negedge sys_clk);
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    apply_reset();

    for (int i = 0; i < 19; i++) begin
      coin_req = tv[i].req; coin_val = tv[i].val; cancel = tv[i].cncl;
      tick();
      chk_all($sformatf("vec%0d", i), tv[i].ack, tv[i].err, tv[i].sl, tv[i].ch,
              tv[i].bz, tv[i].cr);
    end
    cancel = 1'b0; coin_req = '0;

    // Both slots requesting continuously: acks alternate, never back-to-back
    apply_reset();
    coin_req = 2'b11; coin_val = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("alt%0d_ack", i), coin_ack, (i % 2 == 0) ? 1 : 2);
      chk($sformatf("alt%0d_credit", i), credit, i + 1);
    end
    coin_req = 2'b00;
    tick();
    chk("alt_sell", sell, 1);
    tick();
    chk("alt_idle_busy", busy, 0);

    // Credit 3 then cancel: three change pulses spaced G apart, no sell
    load_credit3();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk_all("cncl0", 0, 0, 0, 1, 1, 2);
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t <= 6) chk_all($sformatf("cncl%0d", t), 0, 0, 0, (t % G == 0) ? 1 : 0, 1, 2 - t / G);
      else        chk_all("cncl_end", 0, 0, 0, 0, 0, 0);
    end

    // Async reset during the first change pulse of a 3-unit refund
    load_credit3();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("rstmid_pre_change", change, 1);
    sys_rst = 1'b1;
    #1;
    chk_all("rstmid", 0, 0, 0, 0, 0, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk_all($sformatf("rstmid_after%0d", t), 0, 0, 0, 0, 0, 0);
    end

`ifdef VEND_COIN_TIMEOUT_EN
    // Credit 2 then silence: refund starts TIMEOUT cycles later
    apply_reset();
    coin_req = 2'b01; coin_val = 4'b0010; tick();
    coin_req = 2'b00;
    for (int t = 1; t <= TIMEOUT; t++) begin
      tick();
      if (t < TIMEOUT) chk($sformatf("to%0d_change", t), change, 0);
      else             chk_all("to_fire", 0, 0, 0, 1, 1, 1);
    end
`else
    // Without the timeout, COLLECT holds its credit indefinitely
    apply_reset();
    coin_req = 2'b01; coin_val = 4'b0010; tick();
    coin_req = 2'b00;
    for (int t = 0; t < 30; t++) tick();
    chk_all("hold_collect", 0, 0, 0, 0, 0, 2);
`endif

    // Randomized traffic against the model
    apply_reset();
    model_reset();
    model_on = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      chk_all("rnd", e_ack, e_err, e_sell, e_change, e_busy, e_credit);
      for (int s = 0; s < N_SLOT; s++) begin
        if (coin_req[s] && coin_ack[s]) begin
          coin_req[s] = 1'b0;
        end else if (!coin_req[s] && $urandom_range(0, 2) == 0) begin
          coin_req[s] = 1'b1;
          r = $urandom_range(0, 9);
          coin_val[2*s +: 2] = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 6) ? 2'd1 : 2'd2;
        end
      end
      cancel = ($urandom_range(0, 19) == 0);
    end
    model_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
